// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the multiply sequencer
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MUL_W = 64;

  // Opcode values the EX decode drives onto op_signed
  localparam logic OP_MUL_U = 1'b0;
  localparam logic OP_MUL_S = 1'b1;

endpackage

// File: rtl/cla_adder_w.sv
// rtl/cla_adder_w.sv - N-bit adder from 4-bit carry-lookahead blocks
module cla_adder_w
  import alu_seq_pkg::*;
#(
  parameter int N = MUL_W
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  localparam int NB = N / 4;

  logic [NB:0] c;

  assign c[0] = c_in;

  // Lookahead inside each nibble, block carries ripple between nibbles
  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;

    assign g     = a[4*i +: 4] & b[4*i +: 4];
    assign p     = a[4*i +: 4] ^ b[4*i +: 4];
    assign cc[0] = c[i];
    assign cc[1] = g[0] | (p[0] & cc[0]);
    assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
    assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & cc[0]);
    assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | ((&p) & cc[0]);
    assign s[4*i +: 4] = p ^ cc[3:0];
    assign c[i+1]      = cc[4];
  end

  assign c_out = c[NB];

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add multiply sequencer on a shared CLA adder
// Optional MUL_EARLY_TERM_EN: leave CALC once the remaining multiplier is zero.
module alu_mul_seq
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic             accept;
  logic             calc_last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [PW-1:0]    add_a;
  logic [PW-1:0]    add_b;
  logic             add_cin;
  logic [PW-1:0]    add_s;
  logic             add_cout_unused;

  assign accept = in_valid & in_ready & ~flush;
  assign a_mag  = (op_signed & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag  = (op_signed & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

`ifdef MUL_EARLY_TERM_EN
  assign calc_last = (cnt == CNT_W'(1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign calc_last = (cnt == CNT_W'(1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (flush)          state_nxt = IDLE;
        else if (calc_last) state_nxt = FIX;
      end
      FIX: begin
        if (flush) state_nxt = IDLE;
        else       state_nxt = DONE;
      end
      DONE: begin
        if (flush || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // Adder operands stay at zero outside CALC/FIX so the carry tree does not toggle
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      CALC: begin
        if (mplier[0]) begin
          add_a = acc;
          add_b = mcand;
        end
      end
      FIX: begin
        if (neg) begin
          add_a   = ~acc;
          add_cin = 1'b1;
        end
      end
      default: ;
    endcase
  end

  cla_adder_w #(.N(PW)) u_adder (
    .a     (add_a),
    .b     (add_b),
    .c_in  (add_cin),
    .s     (add_s),
    .c_out (add_cout_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else if (flush && state != IDLE) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
          end
        end
        CALC: begin
          if (mplier[0]) acc <= add_s;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (neg) acc <= add_s;
        end
        default: ;
      endcase
    end
  end

  assign prod_hi = acc[PW-1:WIDTH];
  assign prod_lo = acc[WIDTH-1:0];

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_mul_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_signed (op_signed),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx;
    longint sy;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    return 64'(sx * sy);
  endfunction

  // Edges from accept (counted as edge 1) to the edge after which out_valid is seen
  function automatic int ref_lat(input logic [31:0] y, input logic s);
`ifdef MUL_EARLY_TERM_EN
    logic [31:0] m;
    int hi;
    m  = (s && y[31]) ? (32'd0 - y) : y;
    hi = 0;
    for (int i = 0; i < 32; i++) if (m[i]) hi = i;
    return hi + 3;
`else
    return 34;
`endif
  endfunction

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_req", 64'(in_ready), 64'd1);
    a         = ta;
    b         = tb_;
    op_signed = ts;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic saw_ready);
    lat       = 1;
    saw_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic [63:0] exp);
    int   lat;
    logic sr;
    start_op(ta, tb_, ts);
    wait_done(lat, sr);
    chk({name, "_prod"}, {prod_hi, prod_lo}, exp);
    chk({name, "_lat"}, 64'(lat), 64'(ref_lat(tb_, ts)));
    chk({name, "_busy_no_ready"}, 64'(sr), 64'd0);
    consume();
  endtask

  initial begin
    int          lat;
    logic        sr;
    logic        bad;
    logic [63:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    vecs[0] = '{32'd3,        32'd5,        1'b0, 64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000_0000_0000_0001};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000_0000_8000_0000};
    vecs[4] = '{32'd7,        32'hFFFFFFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[5] = '{32'd100,      32'd1,        1'b0, 64'h0000_0000_0000_0064};
    vecs[6] = '{32'd100,      32'h80000000, 1'b0, 64'h0000_0032_0000_0000};
    vecs[7] = '{32'd0,        32'd12345,    1'b0, 64'h0};
    vecs[8] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000_0000_0000_0000};

    rst_n = 1'b0; in_valid = 1'b0; op_signed = 1'b0; a = '0; b = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);
    end

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 5 == 1) rb = 32'($urandom_range(0, 3));
      if (i % 7 == 2) ra = 32'h80000000;
      run_op($sformatf("rnd%0d", i), ra, rb, rs, ref_mul(ra, rb, rs));
    end

    // Backpressure: product held while out_ready is low, then back-to-back request
    start_op(32'h12345678, 32'h9ABCDEF0, 1'b1);
    wait_done(lat, sr);
    held = {prod_hi, prod_lo};
    chk("bp_prod", held, ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b1));
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || {prod_hi, prod_lo} !== held) bad = 1'b1;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_in_ready_same_cycle", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp_in_ready_next", 64'(in_ready), 64'd1);
    chk("bp_out_valid_dropped", 64'(out_valid), 64'd0);
    a = 32'd11; b = 32'd13; op_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("b2b_accepted", 64'(busy), 64'd1);
    wait_done(lat, sr);
    chk("b2b_prod", {prod_hi, prod_lo}, 64'd143);
    consume();

    // Flush in the tenth CALC cycle
    start_op(32'd9, 32'd9, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_idle", 64'(busy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("flush_no_out", 64'(bad), 64'd0);
    run_op("after_flush", 32'd6, 32'd7, 1'b0, 64'd42);

    // Flush wins over a request presented in IDLE
    @(negedge clk);
    a = 32'd2; b = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_no_accept", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of CALC
    start_op(32'd3, 32'd5, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_prod", {prod_hi, prod_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("mid_rst_no_out", 64'(bad), 64'd0);
    run_op("after_rst", 32'hFFFFFFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
